// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned      FETCH_XLEN     = 32;
  localparam logic [31:0]      FETCH_RESET_PC = 32'h0000_0000;
  // Canonical RISC-V nop (addi x0, x0, 0).
  localparam logic [31:0]      INST_NOP       = 32'h0000_0013;

  // Fetch FSM: one outstanding memory read, one held instruction.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } state_e;

endpackage

// File: rtl/inst_fetch.sv
// Fetch stage: issues one imem read at a time, holds the returned
// instruction for decode, and computes the next pc for the PC register.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
);

  state_e          state_q, state_d;
  logic            drop_q, drop_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;
  logic [XLEN-1:0] redirect_target;

  // Targets are word aligned; the two low bits are dropped.
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Next-state logic for the FSM, drop flag and decode holding registers.
  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    if_valid_d     = if_valid_q;
    if_pc_d        = if_pc_q;
    if_inst_d      = if_inst_q;
    imem_req_valid = 1'b0;
    case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = StWait;
          // Request already left at the old pc; its data must be discarded.
          drop_d  = redirect_valid;
        end
      end
      StWait: begin
        if (imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            if_pc_d    = pc;
            if_inst_d  = imem_resp_data;
            if_valid_d = 1'b1;
            state_d    = StHold;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        // A redirect squashes the held instruction even if decode is ready.
        if (redirect_valid || if_ready) begin
          if_valid_d = 1'b0;
          state_d    = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Next pc mux; pc only moves on redirect, accepted instruction or reset.
  always_comb begin
    npc = pc;
    if (redirect_valid) begin
      npc = redirect_target;
    end else if ((state_q == StHold) && if_ready) begin
      npc = pc + XLEN'(4);
    end else if (state_q == StIdle) begin
      npc = RESET_PC;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign imem_req_addr = pc;
  assign if_valid      = if_valid_q;
  assign if_pc         = if_pc_q;
  assign if_inst       = if_inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // PC register of the surrounding pipeline.
  always @(posedge clk) pc <= npc;

  inst_fetch #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .npc             (npc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: just out of reset, a read in flight (maybe
  // doomed by a redirect), or an instruction held for decode; otherwise the
  // stage is asking memory for the instruction at pc.
  bit          m_known, m_idle, m_pend, m_drop, m_hold;
  logic [31:0] m_hpc, m_hinst;
  logic [31:0] exp_npc;
  bit          exp_req;
  bit          last_fire;

  always @(negedge clk) begin
    exp_req = m_known && !m_idle && !m_pend && !m_hold;
    if (m_known) begin
      if (redirect_valid)           exp_npc = {redirect_pc[31:2], 2'b00};
      else if (m_hold && if_ready)  exp_npc = m_hpc + 32'd4;
      else if (m_idle)              exp_npc = 32'h0;
      else                          exp_npc = pc;
      chk("npc", npc, exp_npc);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) chk("req_addr", imem_req_addr, pc);
      chk("if_valid", 32'(if_valid), 32'(m_hold));
      chk("if_pc", if_pc, m_hpc);
      chk("if_inst", if_inst, m_hinst);
    end
    last_fire = imem_req_valid && imem_req_ready;
    // Advance the model to what the next rising edge must produce.
    if (rst) begin
      m_known = 1; m_idle = 1; m_pend = 0; m_drop = 0; m_hold = 0;
      m_hpc = '0; m_hinst = '0;
    end else if (m_known) begin
      if (m_idle) begin
        m_idle = 0;
      end else if (m_hold) begin
        if (redirect_valid || if_ready) m_hold = 0;
      end else if (m_pend) begin
        if (imem_resp_valid) begin
          m_pend = 0;
          if (m_drop || redirect_valid) begin
            m_drop = 0;
          end else begin
            m_hold = 1; m_hpc = pc; m_hinst = imem_resp_data;
          end
        end else if (redirect_valid) begin
          m_drop = 1;
        end
      end else if (imem_req_ready) begin
        m_pend = 1;
        m_drop = redirect_valid;
      end
    end
  end

  task automatic drive(input bit r, input bit rdv, input logic [31:0] rpc, input bit rqr,
                       input bit rsv, input logic [31:0] rsd, input bit ifr);
    @(posedge clk);
    #1;
    rst = r; redirect_valid = rdv; redirect_pc = rpc; imem_req_ready = rqr;
    imem_resp_valid = rsv; imem_resp_data = rsd; if_ready = ifr;
    @(negedge clk);
  endtask

  bit rpend;
  int rcnt;

  initial begin
    // 1: reset, then IDLE, then the first request at RESET_PC.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t1_req_idle", 32'(imem_req_valid), 32'd0);
    chk("t1_ifv_idle", 32'(if_valid), 32'd0);
    chk("t1_npc_idle", npc, 32'h0);
    drive(0, 0, 0, 1, 0, 0, 1);
    chk("t1_req", 32'(imem_req_valid), 32'd1);
    chk("t1_addr", imem_req_addr, 32'h0);
    // 2: best-case fetch accepted by decode.
    drive(0, 0, 0, 0, 1, 32'h0050_0093, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t2_ifv", 32'(if_valid), 32'd1);
    chk("t2_if_pc", if_pc, 32'h0);
    chk("t2_if_inst", if_inst, 32'h0050_0093);
    chk("t2_npc", npc, 32'h4);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t2_next_addr", imem_req_addr, 32'h4);
    // 3: decode stalls for five cycles.
    drive(0, 0, 0, 0, 1, 32'h00A0_0113, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t3_ifv_held", 32'(if_valid), 32'd1);
      chk("t3_npc_held", npc, 32'h4);
      chk("t3_no_req", 32'(imem_req_valid), 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t3_npc_release", npc, 32'h8);
    // 4: redirect while waiting; the late response is dropped.
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t4_addr", imem_req_addr, 32'h8);
    drive(0, 1, 32'h0000_0102, 0, 0, 0, 0);
    chk("t4_npc_redirect", npc, 32'h0000_0100);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    chk("t4_dropped", 32'(if_valid), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t4_ifv", 32'(if_valid), 32'd0);
    chk("t4_new_addr", imem_req_addr, 32'h0000_0100);
    // 5: wrap of pc+4 at the top of the address space.
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t5_addr", imem_req_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 1, 32'h0000_0013, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t5_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("t5_npc_wrap", npc, 32'h0);
    // 6: reset while waiting; the following response is ignored.
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h1234_5678, 0);
    chk("t6_ifv", 32'(if_valid), 32'd0);
    chk("t6_req_idle", 32'(imem_req_valid), 32'd0);
    chk("t6_npc", npc, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t6_req", 32'(imem_req_valid), 32'd1);
    chk("t6_if_inst", if_inst, 32'h0);

    // Randomized traffic with a memory that answers 1..4 cycles after accept.
    rpend = 0;
    rcnt  = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (last_fire) begin
        rpend = 1;
        rcnt  = int'($urandom_range(0, 3));
      end
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (rpend) begin
        if (rcnt == 0) begin
          imem_resp_valid = 1'b1;
          rpend = 0;
        end else begin
          rcnt--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        imem_resp_valid = 1'b1;
      end
      rst            = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = $urandom_range(0, 1) == 1;
    end
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
